// File: rtl/loader_pkg.sv
// Shared types and constants for the boot-time instruction loader.
// The state enum is used by inst_loader. The word geometry constants are
// used by both inst_loader and word_assembler.
package loader_pkg;

  // Session states. CHECK is only reachable in the checksum build.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN_LO = 3'd1,
    LEN_HI = 3'd2,
    DATA   = 3'd3,
    CHECK  = 3'd4,
    DONE   = 3'd5
  } loaderState_t;

  localparam int BYTES_PER_WORD = 4;
  localparam int LEN_BYTES      = 2;

  // True in the states that consume bytes from the stream.
  function automatic logic isRxPhase(input loaderState_t s);
    return s inside {LEN_LO, LEN_HI, DATA, CHECK};
  endfunction

endpackage

// File: rtl/word_assembler.sv
// word_assembler: packs a byte stream into 32-bit little-endian words.
// Byte k of a word lands in bits [8k+7:8k]. wordFull pulses for one cycle
// after the fourth byte is loaded, while 'word' holds the completed value.
module word_assembler
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        loadEn,
  input  logic [7:0]  dataIn,
  output logic        lastByte,
  output logic [31:0] word,
  output logic        wordFull
);

  logic [1:0] byteIdx;

  assign lastByte = (byteIdx == 2'(BYTES_PER_WORD - 1));

  // Byte lane fill, byte index advance and word-complete pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the word register is reset as well as the index, so that
      // mem_wdata reads 0 after reset instead of stale data.
      byteIdx  <= 2'd0;
      word     <= 32'd0;
      wordFull <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout. Every right-hand side
      // here sees pre-edge values, so wordFull and the byte-lane write use
      // the same byteIdx.
      wordFull <= loadEn && lastByte;
      if (clear) begin
        byteIdx <= 2'd0;
      end else if (loadEn) begin
        word[{byteIdx, 3'b000} +: 8] <= dataIn;
        byteIdx                      <= byteIdx + 2'd1;
      end
    end
  end

endmodule

// File: rtl/inst_loader.sv
// inst_loader: boot-time instruction loader. It receives a framed byte
// stream (16-bit little-endian word count, then little-endian 32-bit words)
// and writes the words to consecutive instruction-memory addresses starting
// at BASE_ADDR, wrapping modulo 2^ADDR_WIDTH. The CPU is held in reset while
// a session runs.
// Optional feature: define LOADER_CHECKSUM_EN to append one checksum byte.
// That byte must equal the XOR of all preceding session bytes. A mismatch
// sets error but does not undo the writes.
module inst_loader
  import loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int BASE_ADDR  = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  output logic                  rx_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  busy,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  error,
  output logic [15:0]           words_loaded
);

  // Instruction-memory capacity in words. Held in 17 bits so that a full
  // 2^16-word memory is still representable.
  localparam logic [16:0] CAPACITY = 17'(1) << ADDR_WIDTH;

`ifdef LOADER_CHECKSUM_EN
  localparam loaderState_t POST_PAYLOAD = CHECK;
`else
  localparam loaderState_t POST_PAYLOAD = DONE;
`endif

  loaderState_t              state;
  logic [8*LEN_BYTES-1:0]    lenReg;
  logic [15:0]               wordsLoadedReg;
  logic                      errorReg;
  logic [ADDR_WIDTH-1:0]     addrReg;

  logic                      accept;
  logic                      startSession;
  logic                      asmLoad;
  logic                      asmLastByte;
  logic                      asmWordFull;
  logic [31:0]               asmWord;
  logic [8*LEN_BYTES-1:0]    lenFull;
  logic                      lastWord;

  assign accept       = rx_ready && rx_valid;
  assign startSession = (state == IDLE) && start;
  assign asmLoad      = accept && (state == DATA);
  assign lenFull      = {rx_data, lenReg[7:0]};
  assign lastWord     = (wordsLoadedReg + 16'd1) == lenReg;

  word_assembler u_assembler (
    .clk      (clk),
    .reset    (reset),
    .clear    (startSession),
    .loadEn   (asmLoad),
    .dataIn   (rx_data),
    .lastByte (asmLastByte),
    .word     (asmWord),
    .wordFull (asmWordFull)
  );

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] checksum;

  // Running XOR of every session byte that precedes the checksum byte.
  always_ff @(posedge clk) begin
    if (reset) begin
      checksum <= 8'd0;
    end else if (startSession) begin
      checksum <= 8'd0;
    end else if (accept && (state != CHECK)) begin
      checksum <= checksum ^ rx_data;
    end
  end
`endif

  // Session FSM: header capture, length validation, word counting, and the
  // error flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      lenReg         <= '0;
      wordsLoadedReg <= 16'd0;
      errorReg       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state          <= LEN_LO;
            errorReg       <= 1'b0;
            wordsLoadedReg <= 16'd0;
          end
        end
        LEN_LO: begin
          if (accept) begin
            lenReg[7:0] <= rx_data;
            state       <= LEN_HI;
          end
        end
        LEN_HI: begin
          if (accept) begin
            lenReg[15:8] <= rx_data;
            if ({1'b0, lenFull} > CAPACITY) begin
              errorReg <= 1'b1;
              state    <= DONE;
            end else if (lenFull == '0) begin
              state <= POST_PAYLOAD;
            end else begin
              state <= DATA;
            end
          end
        end
        DATA: begin
          if (accept && asmLastByte) begin
            // Counts the word that is written to memory on the next cycle.
            wordsLoadedReg <= wordsLoadedReg + 16'd1;
            if (lastWord) begin
              state <= POST_PAYLOAD;
            end
          end
        end
        CHECK: begin
`ifdef LOADER_CHECKSUM_EN
          if (accept) begin
            if (rx_data != checksum) begin
              errorReg <= 1'b1;
            end
            state <= DONE;
          end
`else
          state <= IDLE;
`endif
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Write address: loaded with BASE_ADDR at session start and advanced
  // after each write. Wrapping comes from the natural register width.
  always_ff @(posedge clk) begin
    if (reset) begin
      addrReg <= '0;
    end else if (startSession) begin
      addrReg <= ADDR_WIDTH'(BASE_ADDR);
    end else if (asmWordFull) begin
      addrReg <= addrReg + 1'b1;
    end
  end

  assign rx_ready     = isRxPhase(state);
  assign busy         = (state != IDLE);
  assign cpu_hold     = busy;
  assign done         = (state == DONE);
  assign error        = errorReg;
  assign words_loaded = wordsLoadedReg;
  assign mem_we       = asmWordFull;
  assign mem_addr     = addrReg;
  assign mem_wdata    = asmWord;

endmodule
